// File: rtl/alu_operand_sequencer.sv
// Byte-stream front end for the ALU: collects A, B and opcode, issues them for one cycle, then captures and hands off the result.
// Optional opcode screening is enabled by defining ALU_SEQ_OPCODE_CHECK_EN.
module alu_operand_sequencer #(
    parameter int DATA_BUS       = 8,
    parameter int OP_BUS         = 6,
    parameter int RESULT_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_BUS-1:0] rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [DATA_BUS-1:0] op_a_bus,
    output logic [DATA_BUS-1:0] op_b_bus,
    output logic [OP_BUS-1:0]   op_code_bus,
    output logic [2:0]          enables,
    input  logic [DATA_BUS:0]   result_bus,
    output logic [DATA_BUS:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                error
);

    localparam logic [2:0] LOAD_A  = 3'd0;
    localparam logic [2:0] LOAD_B  = 3'd1;
    localparam logic [2:0] LOAD_OP = 3'd2;
    localparam logic [2:0] ISSUE   = 3'd3;
    localparam logic [2:0] WAIT    = 3'd4;
    localparam logic [2:0] OUTPUT  = 3'd5;

    localparam logic [3:0] WAIT_INIT = 4'(RESULT_LATENCY - 1);

    logic [2:0] state;
    logic [3:0] wait_cnt;
    logic       rx_xfer;

    assign rx_ready = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_OP);
    assign rx_xfer  = rx_valid && rx_ready;
    assign busy     = (state != LOAD_A);
    assign enables  = (state == ISSUE) ? 3'b111 : 3'b000;

`ifdef ALU_SEQ_OPCODE_CHECK_EN
    function automatic logic opcode_legal(input logic [OP_BUS-1:0] op);
        int unsigned v;
        v = 32'(op);
        case (v)
            32'h20, 32'h22, 32'h24, 32'h25,
            32'h26, 32'h27, 32'h02, 32'h03: opcode_legal = 1'b1;
            default:                        opcode_legal = 1'b0;
        endcase
    endfunction
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= LOAD_A;
            wait_cnt    <= 4'd0;
            op_a_bus    <= '0;
            op_b_bus    <= '0;
            op_code_bus <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
            error       <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD_A: if (rx_xfer) begin
                    op_a_bus <= rx_data;
                    state    <= LOAD_B;
                end
                LOAD_B: if (rx_xfer) begin
                    op_b_bus <= rx_data;
                    state    <= LOAD_OP;
                end
                LOAD_OP: if (rx_xfer) begin
`ifdef ALU_SEQ_OPCODE_CHECK_EN
                    // Rejected opcodes never reach the ALU; the previous opcode stays on the bus.
                    if (opcode_legal(rx_data[OP_BUS-1:0])) begin
                        op_code_bus <= rx_data[OP_BUS-1:0];
                        state       <= ISSUE;
                    end else begin
                        error <= 1'b1;
                        state <= LOAD_A;
                    end
`else
                    op_code_bus <= rx_data[OP_BUS-1:0];
                    state       <= ISSUE;
`endif
                end
                ISSUE: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
                    error    <= 1'b0;
`endif
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        tx_data  <= result_bus;
                        tx_valid <= 1'b1;
                        state    <= OUTPUT;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                OUTPUT: if (tx_ready) begin
                    // tx_valid is already high here, so a ready coinciding with its rise is not a handshake.
                    tx_valid <= 1'b0;
                    state    <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule
